iob_eth_mdio: RTL
=================

Name: iob_eth_mdio

Overview:
MII management (MDIO/MDC) master that sits directly downstream of the Ethernet core's MIIMODER/MIICOMMAND/MIIADDRESS/MIITX_DATA registers. It replaces the core's tied-off mii_mdc_o with a real Clause-22 serial engine toward the PHY. It converts one register-level read or write command into an IEEE 802.3 Clause-22 frame on MDC/MDIO, and returns read data plus a PHY-response status to MIIRX_DATA/MIISTATUS.

Parameters:
DIV_W, 8, width of the clock-divider input.
PRE_BITS, 32, preamble length in bits (all ones).

Ports:
clk_i  input  1  system clock
arst_n_i  input  1  asynchronous, active-low reset
cke_i  input  1  clock enable; all state frozen when 0
clkdiv_i  input  DIV_W  MDC half-period in clk_i cycles; values 0 and 1 are treated as 2
start_rd_i  input  1  read command pulse
start_wr_i  input  1  write command pulse
phy_addr_i  input  5  PHY address
reg_addr_i  input  5  register address
wdata_i  input  16  write data
rdata_o  output  16  last read data
nvalid_o  output  1  PHY did not drive TA low on the last read
busy_o  output  1  frame in progress
done_o  output  1  one-cycle completion pulse
mdc_o  output  1  management clock to the PHY
mdio_o  output  1  MDIO output value
mdio_oe_o  output  1  MDIO output enable (tristate at the top level)
mdio_i  input  1  MDIO input

Behaviour:
- Reset values: rdata_o=0, nvalid_o=0, busy_o=0, done_o=0, mdc_o=0, mdio_o=1, mdio_oe_o=0. State=IDLE.
- Reset is asynchronous and takes effect immediately, including mid-frame: MDIO is released and no done_o is produced.
- States: IDLE -> LOW -> HIGH -> (LOW | FINISH) -> IDLE.
- IDLE:
  - A start is accepted at a cycle t when start_rd_i or start_wr_i is high.
  - If both are high, the command is a read.
  - The command, addresses, wdata_i and H=max(clkdiv_i,2) are latched at t.
  - busy_o=1 from t+1.
  - Starts arriving while busy_o=1 are ignored.
- Frame bit index b runs 0..PRE_BITS+31:
  - Preamble: all ones.
  - ST = 01.
  - OP = 10 for read, 01 for write.
  - PHYAD[4:0], then REGAD[4:0], both MSB first.
  - TA = 10 for write; released for read.
  - DATA[15:0], MSB first.
- LOW: lasts H cycles.
  - mdc_o=0.
  - mdio_o and mdio_oe_o are updated on entry to the value for bit b.
  - Read: mdio_oe_o=0 from the first TA bit to the end of the frame.
  - Write: mdio_oe_o=1 for the whole frame.
- HIGH: lasts H cycles with mdc_o=1.
  - On entry to HIGH (rising MDC), a read samples mdio_i.
  - At the second TA bit the sample goes to the nvalid flag (1 = no response).
  - During DATA the sample is shifted into the read shift register.
  - After the last bit, go to FINISH; otherwise b++ and return to LOW.
- FINISH (1 cycle):
  - done_o=1, busy_o=0, mdio_oe_o=0, mdio_o=1, mdc_o=0.
  - On a read, rdata_o and nvalid_o are updated. A write leaves both unchanged.
- Latency: with N frame bits, done_o is high at cycle t+1+2*H*N.
- Latched H and command fields are immune to input changes during a frame.
- Bit counter width: ceil(log2(PRE_BITS+32)). Half-period counter width: DIV_W.

Optional Feature:
- Macro: IOB_ETH_MDIO_NOPRE_EN.
- Defined: adds input no_pre_i, latched at start. When 1, the preamble is skipped (the frame starts at ST, N=32). When 0, N=PRE_BITS+32.
- Undefined: no such port; the preamble is always sent.

Decomposition:
- Shared constants header iob_eth_mdio_defs.vh contains:
  - ST/OP/TA codes.
  - Field bit offsets (ST=PRE_BITS, OP=PRE_BITS+2, PHYAD=+4, REGAD=+9, TA=+14, DATA=+16).
  - State encodings.
- One natural sub-module, iob_eth_mdio_clkgen:
  - Half-period down-counter producing a one-cycle "phase end" strobe.
  - Held in reload while idle.
- The FSM, shift registers and bit counter stay in iob_eth_mdio.

Test Plan:
1. Reset: hold arst_n_i=0, then release with no start -> all outputs at reset values, mdc_o static 0 for 1000 cycles.
2. Write, clkdiv_i=4, phy=5'h01, reg=5'h00, wdata=16'h1200, start at t.
   - busy_o high from t+1.
   - Serial bit stream sampled at MDC rising edges = 32x1, 01, 01, 00001, 00000, 10, 0x1200 MSB first.
   - done_o high only at t+513; mdio_oe_o=1 throughout the frame.
3. Read, clkdiv_i=2, PHY model drives TA0=0 then 0x796D.
   - mdio_oe_o falls at the TA bit.
   - rdata_o=16'h796D and nvalid_o=0 at done_o, which occurs at t+257.
4. Read with the PHY absent (pull-up, mdio_i=1) -> rdata_o=16'hFFFF, nvalid_o=1. A following write leaves both unchanged.
5. Boundaries:
   - clkdiv_i=0 behaves as 2.
   - start_wr_i re-pulsed mid-frame is ignored.
   - start_rd_i and start_wr_i together produce OP=10.
   - arst_n_i asserted at bit 40 gives immediate IDLE, mdio_oe_o=0, no done_o.
6. IOB_ETH_MDIO_NOPRE_EN defined with no_pre_i=1 and clkdiv_i=2 -> frame starts with 01, done_o at t+129.

Source files
------------

// File: rtl/iob_eth_mdio_pkg.sv
// Shared constants for the Clause-22 MDIO master: frame codes, field offsets, FSM states.
// Field offsets are relative to the end of the preamble (PRE_BITS).
package iob_eth_mdio_pkg;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FINISH} state_t;

  localparam logic [1:0] ST_CODE = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] TA_WR   = 2'b10;

  localparam int OFF_ST   = 0;
  localparam int OFF_OP   = 2;
  localparam int OFF_PHY  = 4;
  localparam int OFF_REG  = 9;
  localparam int OFF_TA   = 14;
  localparam int OFF_DATA = 16;

  typedef struct packed {
    logic        rd;
    logic [4:0]  phy;
    logic [4:0]  regad;
    logic [15:0] wdata;
  } cmd_t;

endpackage

// File: rtl/iob_eth_mdio_if.sv
// Register-side command/status bus of the MDIO master.
interface iob_eth_mdio_if;
  logic        start_rd_i;
  logic        start_wr_i;
  logic [4:0]  phy_addr_i;
  logic [4:0]  reg_addr_i;
  logic [15:0] wdata_i;
  logic [15:0] rdata_o;
  logic        nvalid_o;
  logic        busy_o;
  logic        done_o;

  modport slave (
    input  start_rd_i, start_wr_i, phy_addr_i, reg_addr_i, wdata_i,
    output rdata_o, nvalid_o, busy_o, done_o
  );
  modport master (
    output start_rd_i, start_wr_i, phy_addr_i, reg_addr_i, wdata_i,
    input  rdata_o, nvalid_o, busy_o, done_o
  );
endinterface

// File: rtl/iob_eth_mdio_clkgen.sv
// MDC half-period timer: one-cycle phase_end strobe every half_i cycles while running.
// Held in reload while not running so the first phase starts with a full count.
module iob_eth_mdio_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic             run_i,
  input  logic [DIV_W-1:0] half_i,
  output logic             phase_end_o
);
  logic [DIV_W-1:0] cnt;

  assign phase_end_o = run_i && (cnt == '0);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i)                   cnt <= '0;
    else if (cke_i) begin
      if (!run_i || cnt == '0)       cnt <= half_i - DIV_W'(1);
      else                           cnt <= cnt - DIV_W'(1);
    end
  end
endmodule

// File: rtl/iob_eth_mdio.sv
// Clause-22 MDIO/MDC master: one register-level read or write becomes one serial frame.
// Optional IOB_ETH_MDIO_NOPRE_EN adds no_pre_i to skip the preamble.
module iob_eth_mdio
  import iob_eth_mdio_pkg::*;
#(
  parameter int DIV_W    = 8,
  parameter int PRE_BITS = 32
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             cke_i,
  input  logic [DIV_W-1:0] clkdiv_i,
`ifdef IOB_ETH_MDIO_NOPRE_EN
  input  logic             no_pre_i,
`endif
  iob_eth_mdio_if.slave    bus,
  output logic             mdc_o,
  output logic             mdio_o,
  output logic             mdio_oe_o,
  input  logic             mdio_i
);
  localparam int BW = $clog2(PRE_BITS + 32);
  localparam logic [BW-1:0] B_PRE  = BW'(PRE_BITS);
  localparam logic [BW-1:0] B_TA2  = BW'(PRE_BITS + OFF_TA + 1);
  localparam logic [BW-1:0] B_DATA = BW'(PRE_BITS + OFF_DATA);
  localparam logic [BW-1:0] B_LAST = BW'(PRE_BITS + 31);

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [DIV_W-1:0] h_q, h_in, half;
  logic [BW-1:0]    bit_q, bit_d, nxt_idx, first_idx, rel;
  logic [15:0]      sreg_q, rdata_q;
  logic             nv_q, nvalid_q;
  logic             start, accept, run, phase_end;
  logic             nxt_val, nxt_oe, sample, fin, mdc_d, mdo_d, oe_d;
  logic [31:0]      tx_word;

`ifdef IOB_ETH_MDIO_NOPRE_EN
  assign first_idx = no_pre_i ? B_PRE : '0;
`else
  assign first_idx = '0;
`endif

  assign start  = bus.start_rd_i | bus.start_wr_i;
  assign accept = (state_q == IDLE) && start;
  assign h_in   = (clkdiv_i < DIV_W'(2)) ? DIV_W'(2) : clkdiv_i;
  assign half   = (state_q == IDLE) ? h_in : h_q;
  assign run    = (state_q == LOW) || (state_q == HIGH);

  iob_eth_mdio_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk_i       (clk_i),
    .arst_n_i    (arst_n_i),
    .cke_i       (cke_i),
    .run_i       (run),
    .half_i      (half),
    .phase_end_o (phase_end)
  );

  always_comb begin
    cmd_d = cmd_q;
    if (accept) begin
      cmd_d.rd    = bus.start_rd_i;
      cmd_d.phy   = bus.phy_addr_i;
      cmd_d.regad = bus.reg_addr_i;
      cmd_d.wdata = bus.wdata_i;
    end
  end

  // Everything after the preamble, MSB first; released read bits read as 1.
  assign tx_word = {ST_CODE, cmd_d.rd ? OP_RD : OP_WR, cmd_d.phy, cmd_d.regad,
                    cmd_d.rd ? 2'b11 : TA_WR, cmd_d.rd ? 16'hFFFF : cmd_d.wdata};
  assign nxt_idx = (state_q == IDLE) ? first_idx : bit_q + BW'(1);
  assign rel     = nxt_idx - B_PRE;
  assign nxt_val = (nxt_idx < B_PRE) ? 1'b1 : tx_word[5'd31 - rel[4:0]];
  assign nxt_oe  = (nxt_idx < B_PRE) || !cmd_d.rd || (rel < BW'(OFF_TA));

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    mdc_d   = mdc_o;
    mdo_d   = mdio_o;
    oe_d    = mdio_oe_o;
    sample  = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = LOW;
        bit_d   = nxt_idx;
        mdc_d   = 1'b0;
        mdo_d   = nxt_val;
        oe_d    = nxt_oe;
      end
      LOW: if (phase_end) begin
        state_d = HIGH;
        mdc_d   = 1'b1;
        sample  = 1'b1;
      end
      HIGH: if (phase_end) begin
        mdc_d = 1'b0;
        if (bit_q == B_LAST) begin
          state_d = FINISH;
          mdo_d   = 1'b1;
          oe_d    = 1'b0;
          fin     = 1'b1;
        end else begin
          state_d = LOW;
          bit_d   = nxt_idx;
          mdo_d   = nxt_val;
          oe_d    = nxt_oe;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      h_q       <= DIV_W'(2);
      bit_q     <= '0;
      sreg_q    <= '0;
      nv_q      <= 1'b0;
      rdata_q   <= '0;
      nvalid_q  <= 1'b0;
      mdc_o     <= 1'b0;
      mdio_o    <= 1'b1;
      mdio_oe_o <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      bit_q     <= bit_d;
      mdc_o     <= mdc_d;
      mdio_o    <= mdo_d;
      mdio_oe_o <= oe_d;
      if (accept) h_q <= h_in;
      // mdio_i is sampled on the edge that raises MDC
      if (sample && cmd_q.rd) begin
        if (bit_q == B_TA2)  nv_q   <= mdio_i;
        if (bit_q >= B_DATA) sreg_q <= {sreg_q[14:0], mdio_i};
      end
      if (fin && cmd_q.rd) begin
        rdata_q  <= sreg_q;
        nvalid_q <= nv_q;
      end
    end
  end

  assign bus.rdata_o  = rdata_q;
  assign bus.nvalid_o = nvalid_q;
  assign bus.busy_o   = run;
  assign bus.done_o   = (state_q == FINISH);
endmodule
